// File: rtl/fc_mac_arbiter.sv
// Round-robin arbiter/sequencer that shares one MAC datapath among NREQ clients.
// Each grant runs clear -> N operand beats -> L-cycle drain -> held response.
module fc_mac_arbiter #(
  parameter int NREQ = 4,
  parameter int T    = 16,
  parameter int N    = 8,
  parameter int L    = 3,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*T-1:0] req_x,
  input  logic [NREQ*T-1:0] req_w,
  output logic [NREQ-1:0]   grant,
  output logic              dp_clear,
  output logic              dp_en,
  output logic [T-1:0]      dp_x,
  output logic [T-1:0]      dp_w,
  input  logic [T-1:0]      dp_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [T-1:0]      rsp_data,
  output logic [IDW-1:0]    rsp_id
);

  localparam int BCW = $clog2(N + 1);
  localparam int DCW = $clog2(L + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_STREAM,
    S_DRAIN,
    S_RESP
  } state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [IDW-1:0] win_q, win_d;
  logic [BCW-1:0] beat_cnt_q, beat_cnt_d;
  logic [DCW-1:0] drain_cnt_q, drain_cnt_d;
  logic [T-1:0]   rsp_data_q, rsp_data_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;

  logic           pick_found;
  logic [IDW-1:0] pick_idx;
  logic [IDW-1:0] cand;
  logic [NREQ-1:0] win_oh;
  logic           accept;

  // First requester at or above ptr, wrapping modulo NREQ (not modulo 2^IDW).
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IDW'((32'(ptr_q) + i) % NREQ);
      if (!pick_found && req_valid[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    win_oh        = '0;
    win_oh[win_q] = 1'b1;
  end

  assign accept = (state_q == S_STREAM) && req_valid[win_q];

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    win_d       = win_q;
    beat_cnt_d  = beat_cnt_q;
    drain_cnt_d = drain_cnt_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    unique case (state_q)
      S_IDLE: begin
        if (pick_found) begin
          win_d   = pick_idx;
          state_d = S_CLEAR;
        end
      end
      S_CLEAR: begin
        beat_cnt_d = '0;
        state_d    = S_STREAM;
      end
      S_STREAM: begin
        if (accept) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          if (beat_cnt_q == BCW'(N - 1)) begin
            drain_cnt_d = '0;
            state_d     = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == DCW'(L - 1)) begin
          rsp_data_d = dp_result;
          rsp_id_d   = win_q;
          state_d    = S_RESP;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          ptr_d   = (int'(win_q) == NREQ - 1) ? '0 : win_q + 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      win_q       <= '0;
      beat_cnt_q  <= '0;
      drain_cnt_q <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      win_q       <= win_d;
      beat_cnt_q  <= beat_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
    end
  end

  always_comb begin
    grant     = (state_q != S_IDLE) ? win_oh : '0;
    req_ready = (state_q == S_STREAM) ? win_oh : '0;
    dp_clear  = (state_q == S_CLEAR);
    dp_en     = accept;
    dp_x      = accept ? req_x[int'(win_q)*T +: T] : '0;
    dp_w      = accept ? req_w[int'(win_q)*T +: T] : '0;
    rsp_valid = (state_q == S_RESP);
    rsp_data  = rsp_data_q;
    rsp_id    = rsp_id_q;
  end

endmodule

// File: tb/tb_fc_mac_arbiter.sv
// Scoreboard bench for fc_mac_arbiter with a behavioural saturating-MAC/ReLU datapath.
module tb_fc_mac_arbiter;
  localparam int NREQ = 4;
  localparam int T    = 16;
  localparam int N    = 8;
  localparam int L    = 3;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [NREQ-1:0]   req_valid, req_ready, grant;
  logic [NREQ*T-1:0] req_x, req_w;
  logic              dp_clear, dp_en, rsp_valid, rsp_ready;
  logic [T-1:0]      dp_x, dp_w, dp_result, rsp_data;
  logic [IDW-1:0]    rsp_id;

  fc_mac_arbiter #(.NREQ(NREQ), .T(T), .N(N), .L(L)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_w(req_w), .grant(grant), .dp_clear(dp_clear),
    .dp_en(dp_en), .dp_x(dp_x), .dp_w(dp_w), .dp_result(dp_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_id(rsp_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [T-1:0] sat(input longint v);
    longint maxv = (longint'(1) << (T - 1)) - 1;
    if (v > maxv) return T'(maxv);
    if (v < -maxv - 1) return T'(-maxv - 1);
    return T'(v);
  endfunction

  function automatic logic [T-1:0] exp_sum(input int bx, input int w);
    logic signed [T-1:0] acc = '0;
    for (int k = 0; k < N; k++) acc = sat(longint'(acc) + longint'(bx + k) * longint'(w));
    return (acc < 0) ? '0 : acc;
  endfunction

  // Datapath model: accumulator then L-1 pipeline stages, ReLU on the output.
  logic signed [T-1:0] acc = '0, p1 = '0, p2 = '0;
  always @(posedge clk) begin
    if (dp_clear) acc <= '0;
    else if (dp_en) acc <= sat(longint'(acc) + longint'($signed(dp_x)) * longint'($signed(dp_w)));
    p1 <= acc;
    p2 <= p1;
  end
  assign dp_result = (p2 < 0) ? '0 : p2;

  typedef struct { int bx; int w; } job_t;
  typedef struct { int id; logic [T-1:0] data; } exp_t;

  job_t jq[NREQ][$];
  exp_t sb[$];
  int   idx[NREQ], cur_bx[NREQ], cur_w[NREQ], start_cyc[NREQ];
  int   stall_beat[NREQ], stall_rem[NREQ];
  bit   act[NREQ];
  logic [NREQ-1:0] hs_seen;

  // Client driver: beats advance one posedge after a handshake is seen.
  initial begin
    forever begin
      @(negedge clk);
      hs_seen = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (hs_seen[i] && act[i]) begin
          idx[i]++;
          if (idx[i] == N) act[i] = 1'b0;
        end
        if (!act[i] && jq[i].size() > 0) begin
          job_t j;
          j = jq[i].pop_front();
          cur_bx[i] = j.bx;
          cur_w[i] = j.w;
          idx[i] = 0;
          act[i] = 1'b1;
          start_cyc[i] = cyc;
        end
        req_valid[i] = act[i];
        if (act[i] && idx[i] == stall_beat[i] && stall_rem[i] > 0) begin
          req_valid[i] = 1'b0;
          stall_rem[i]--;
        end
        req_x[i*T +: T] = act[i] ? T'(cur_bx[i] + idx[i]) : '0;
        req_w[i*T +: T] = act[i] ? T'(cur_w[i]) : '0;
      end
    end
  end

  int  en_cnt = 0, clr_cyc = 0, first_en = 0, last_en = 0, dp_bad = 0;
  int  rise_cyc = 0, prev_rise = 0;
  bit  rsp_prev = 1'b0, have_prev = 1'b0, period_mode = 1'b0;

  initial begin
    forever begin
      @(negedge clk);
      if (dp_clear) begin
        clr_cyc = cyc;
        en_cnt = 0;
      end
      if (dp_en) begin
        if (en_cnt == 0) first_en = cyc;
        last_en = cyc;
        en_cnt++;
      end else if (dp_x != '0 || dp_w != '0) begin
        dp_bad++;
      end
      if (rsp_valid && !rsp_prev) rise_cyc = cyc;
      rsp_prev = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          check("rsp_unexpected", sb.size(), 1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("rsp_id", rsp_id, e.id);
          check("rsp_data", rsp_data, e.data);
          check("dp_en_pulses", en_cnt, N);
        end
        if (period_mode && have_prev) check("job_period", rise_cyc - prev_rise, N + L + 3);
        prev_rise = rise_cyc;
        have_prev = 1'b1;
      end
    end
  end

  task automatic submit(input int id, input int bx, input int w);
    job_t j;
    exp_t e;
    j.bx = bx;
    j.w = w;
    jq[id].push_back(j);
    e.id = id;
    e.data = exp_sum(bx, w);
    sb.push_back(e);
  endtask

  task automatic flush();
    for (int i = 0; i < NREQ; i++) begin
      jq[i].delete();
      act[i] = 1'b0;
      idx[i] = 0;
      stall_rem[i] = 0;
    end
    req_valid = '0;
    sb.delete();
    have_prev = 1'b0;
  endtask

  // Called at a negedge; holds reset low across one rising edge.
  task automatic apply_reset(input string tag);
    reset = 1'b0;
    flush();
    @(negedge clk);
    check({tag, "_req_ready"}, req_ready, 0);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_dp_clear"}, dp_clear, 0);
    check({tag, "_dp_en"}, dp_en, 0);
    check({tag, "_dp_x"}, dp_x, 0);
    check({tag, "_dp_w"}, dp_w, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_data"}, rsp_data, 0);
    check({tag, "_rsp_id"}, rsp_id, 0);
    reset = 1'b1;
  endtask

  task automatic wait_rsp(output int c);
    c = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rsp_valid) begin
        c = cyc;
        return;
      end
    end
    check("wait_rsp_timeout", rsp_valid, 1);
  endtask

  task automatic wait_done();
    bit busy;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      busy = rsp_valid || sb.size() != 0;
      for (int i = 0; i < NREQ; i++) if (act[i] || jq[i].size() != 0) busy = 1'b1;
      if (!busy) return;
    end
    check("wait_done_timeout", sb.size(), 0);
  endtask

  initial begin
    int c;
    req_valid = '0;
    req_x = '0;
    req_w = '0;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      stall_beat[i] = -1;
      stall_rem[i] = 0;
      act[i] = 1'b0;
      idx[i] = 0;
    end
    repeat (2) @(negedge clk);
    apply_reset("rst0");

    // Single client latency profile
    @(negedge clk);
    submit(1, 1, 2);
    wait_rsp(c);
    check("t1_rsp_latency", c - start_cyc[1], N + L + 2);
    check("t1_clear_cyc", clr_cyc - start_cyc[1], 1);
    check("t1_first_en", first_en - start_cyc[1], 2);
    check("t1_last_en", last_en - start_cyc[1], N + 1);
    wait_done();

    // All clients requesting: round-robin 0,1,2,3,0 at full rate
    @(negedge clk);
    apply_reset("rst2");
    period_mode = 1'b1;
    submit(0, 1, 1);
    submit(1, 4, 2);
    submit(2, 7, 3);
    submit(3, 10, -2);
    submit(0, 10, 3);
    wait_done();
    period_mode = 1'b0;

    // ptr=2 after serving client 1; then 3 before 0, leaving ptr=1
    apply_reset("rst3");
    submit(1, 2, 1);
    wait_done();
    submit(3, 5, 2);
    submit(0, 3, 3);
    wait_done();
    submit(1, 1, 1);
    submit(2, 2, 2);
    submit(0, 3, 3);
    wait_done();

    // Client stalls for 3 cycles after beat 4
    apply_reset("rst4");
    stall_beat[0] = 4;
    stall_rem[0] = 3;
    submit(0, 2, 3);
    wait_rsp(c);
    check("t4_rsp_latency", c - start_cyc[0], N + L + 2 + 3);
    wait_done();
    stall_beat[0] = -1;

    // Response backpressure with another request pending
    apply_reset("rst5");
    rsp_ready = 1'b0;
    submit(0, 3, 5);
    submit(1, 1, 4);
    wait_rsp(c);
    for (int k = 0; k < 5; k++) begin
      check("t5_rsp_valid", rsp_valid, 1);
      check("t5_rsp_data", rsp_data, exp_sum(3, 5));
      check("t5_rsp_id", rsp_id, 0);
      check("t5_grant", grant, 4'b0001);
      if (k < 4) @(negedge clk);
    end
    @(posedge clk);
    #1 rsp_ready = 1'b1;
    wait_done();

    // Reset mid-stream aborts the job and returns ptr to 0
    apply_reset("rst6");
    submit(2, 1, 1);
    wait_done();
    submit(2, 3, 4);
    begin
      bit hit = 1'b0;
      for (int k = 0; k < 100 && !hit; k++) begin
        @(negedge clk);
        if (act[2] && idx[2] == 4) hit = 1'b1;
      end
      check("t6_reach_beat5", hit, 1);
    end
    apply_reset("t6_abort");
    submit(1, 2, 2);
    submit(3, 1, 5);
    wait_done();

    check("dp_idle_zero", dp_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
